// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS ID/EX stage: ALU select codes, opcode and
// funct encodings, and the control bundle carried down the pipeline.
package mips_pkg;

  // ALU select codes
  localparam logic [3:0] ALU_ZERO = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_MULT = 4'b0011;
  localparam logic [3:0] ALU_DIV  = 4'b0100;
  localparam logic [3:0] ALU_AND  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_XOR  = 4'b1001;

  // Opcodes, instruction[31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes, instruction[5:0]
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_DIV  = 6'h1A;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/alu_decode.sv
// Combinational opcode/funct decoder.
// Ports:
//   opcode, funct  in   instruction fields
//   alu_sel        out  4-bit ALU select code (ALU_ZERO when unknown)
//   sign_ext       out  1 = sign-extend imm16, 0 = zero-extend
//   b_is_rt        out  1 = ALU B operand is rt, 0 = extended immediate
//   dest_is_rd     out  1 = write-back register is rd, 0 = rt
//   ctrl           out  control bundle (all zero when unknown)
import mips_pkg::*;

module alu_decode (
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_sel,
  output logic       sign_ext,
  output logic       b_is_rt,
  output logic       dest_is_rd,
  output ctrl_t      ctrl
);

  always_comb begin
    alu_sel    = ALU_ZERO;
    sign_ext   = 1'b1;
    b_is_rt    = 1'b0;
    dest_is_rd = 1'b0;
    ctrl       = CTRL_NONE;
    case (opcode)
      OP_RTYPE: begin
        dest_is_rd = 1'b1;
        b_is_rt    = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: alu_sel = ALU_ADD;
          FN_SUB, FN_SUBU: alu_sel = ALU_SUB;
          FN_MULT:         alu_sel = ALU_MULT;
          FN_DIV:          alu_sel = ALU_DIV;
          FN_AND:          alu_sel = ALU_AND;
          FN_OR:           alu_sel = ALU_OR;
          FN_NOR:          alu_sel = ALU_NOR;
          FN_SLT:          alu_sel = ALU_SLT;
          FN_XOR:          alu_sel = ALU_XOR;
          default:         alu_sel = ALU_ZERO;
        endcase
        // Unknown funct leaves every control bit low.
        ctrl.reg_write = (alu_sel != ALU_ZERO);
      end
      OP_ADDI, OP_ADDIU: begin
        alu_sel        = ALU_ADD;
        ctrl.reg_write = 1'b1;
      end
      OP_SLTI: begin
        alu_sel        = ALU_SLT;
        ctrl.reg_write = 1'b1;
      end
      OP_ANDI: begin
        alu_sel        = ALU_AND;
        sign_ext       = 1'b0;
        ctrl.reg_write = 1'b1;
      end
      OP_ORI: begin
        alu_sel        = ALU_OR;
        sign_ext       = 1'b0;
        ctrl.reg_write = 1'b1;
      end
      OP_XORI: begin
        alu_sel        = ALU_XOR;
        sign_ext       = 1'b0;
        ctrl.reg_write = 1'b1;
      end
      OP_LW: begin
        alu_sel        = ALU_ADD;
        ctrl.reg_write = 1'b1;
        ctrl.mem_read  = 1'b1;
      end
      OP_SW: begin
        alu_sel        = ALU_ADD;
        ctrl.mem_write = 1'b1;
      end
      OP_BEQ: begin
        alu_sel     = ALU_SUB;
        b_is_rt     = 1'b1;
        ctrl.branch = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU-select decode, immediate extension and
// EX/MEM / MEM/WB operand forwarding. Supports stall (hold) and flush (bubble).
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   stall, flush, valid_in     pipeline control from hazard unit / decode
//   opcode, funct, imm16       instruction fields
//   rs_addr/rt_addr/rd_addr    register specifiers
//   rs_data, rt_data           register-file read data
//   exmem_*, memwb_*           forwarding sources
//   alu_a, alu_b, alu_sel      ALU operands and select
//   store_data                 forwarded rt value for stores
//   dest_addr, reg_write, mem_read, mem_write, branch, valid_out
import mips_pkg::*;

module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        valid_in,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [15:0] imm16,
  input  logic [4:0]  exmem_rd,
  input  logic        exmem_we,
  input  logic [31:0] exmem_res,
  input  logic [4:0]  memwb_rd,
  input  logic        memwb_we,
  input  logic [31:0] memwb_res,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_sel,
  output logic [31:0] store_data,
  output logic [4:0]  dest_addr,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        branch,
  output logic        valid_out
);

  // Decode of the incoming instruction
  logic [3:0]  dec_sel;
  logic        dec_sign_ext;
  logic        dec_b_is_rt;
  logic        dec_dest_is_rd;
  ctrl_t       dec_ctrl;
  ctrl_t       ctrl_d;
  logic [4:0]  dest_d;
  logic [31:0] imm_ext_d;

  alu_decode u_alu_decode (
    .opcode     (opcode),
    .funct      (funct),
    .alu_sel    (dec_sel),
    .sign_ext   (dec_sign_ext),
    .b_is_rt    (dec_b_is_rt),
    .dest_is_rd (dec_dest_is_rd),
    .ctrl       (dec_ctrl)
  );

  always_comb begin
    dest_d    = dec_dest_is_rd ? rd_addr : rt_addr;
    imm_ext_d = dec_sign_ext ? {{16{imm16[15]}}, imm16} : {16'h0000, imm16};
    ctrl_d    = dec_ctrl;
    // Writes to $zero are architecturally discarded.
    if (dest_d == 5'd0) ctrl_d.reg_write = 1'b0;
  end

  // Pipeline registers
  logic        valid_q;
  logic [3:0]  sel_q;
  ctrl_t       ctrl_q;
  logic [4:0]  dest_q;
  logic [4:0]  rs_addr_q;
  logic [4:0]  rt_addr_q;
  logic [31:0] rs_data_q;
  logic [31:0] rt_data_q;
  logic [31:0] imm_q;
  logic        b_is_rt_q;

  // Forwarding on the registered specifiers; EX/MEM wins over MEM/WB.
  logic [31:0] fwd_rs;
  logic [31:0] fwd_rt;

  always_comb begin
    fwd_rs = rs_data_q;
    if (rs_addr_q != 5'd0) begin
      if (exmem_we && (exmem_rd == rs_addr_q))      fwd_rs = exmem_res;
      else if (memwb_we && (memwb_rd == rs_addr_q)) fwd_rs = memwb_res;
    end
    fwd_rt = rt_data_q;
    if (rt_addr_q != 5'd0) begin
      if (exmem_we && (exmem_rd == rt_addr_q))      fwd_rt = exmem_res;
      else if (memwb_we && (memwb_rd == rt_addr_q)) fwd_rt = memwb_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      sel_q     <= ALU_ZERO;
      ctrl_q    <= CTRL_NONE;
      dest_q    <= 5'd0;
      rs_addr_q <= 5'd0;
      rt_addr_q <= 5'd0;
      rs_data_q <= 32'd0;
      rt_data_q <= 32'd0;
      imm_q     <= 32'd0;
      b_is_rt_q <= 1'b0;
    end else if (flush || (!stall && !valid_in)) begin
      valid_q   <= 1'b0;
      sel_q     <= ALU_ZERO;
      ctrl_q    <= CTRL_NONE;
      dest_q    <= 5'd0;
      rs_addr_q <= 5'd0;
      rt_addr_q <= 5'd0;
      rs_data_q <= 32'd0;
      rt_data_q <= 32'd0;
      imm_q     <= 32'd0;
      b_is_rt_q <= 1'b0;
    end else if (stall) begin
      // Capture forwarded values so a producer retiring mid-stall is kept.
      rs_data_q <= fwd_rs;
      rt_data_q <= fwd_rt;
    end else begin
      valid_q   <= 1'b1;
      sel_q     <= dec_sel;
      ctrl_q    <= ctrl_d;
      dest_q    <= dest_d;
      rs_addr_q <= rs_addr;
      rt_addr_q <= rt_addr;
      rs_data_q <= rs_data;
      rt_data_q <= rt_data;
      imm_q     <= imm_ext_d;
      b_is_rt_q <= dec_b_is_rt;
    end
  end

  always_comb begin
    alu_a      = fwd_rs;
    alu_b      = b_is_rt_q ? fwd_rt : imm_q;
    store_data = fwd_rt;
    dest_addr  = dest_q;
    valid_out  = valid_q;
    alu_sel    = valid_q ? sel_q : ALU_ZERO;
    reg_write  = valid_q & ctrl_q.reg_write;
    mem_read   = valid_q & ctrl_q.mem_read;
    mem_write  = valid_q & ctrl_q.mem_write;
    branch     = valid_q & ctrl_q.branch;
  end

endmodule
